// File: rtl/psum_accumulate.sv
// Accumulates num_acc signed partial-sum beats per output pixel, saturates to I+F bits with
// optional ReLU, and buffers results in a small valid/ready FIFO for writeback.
module psum_accumulate #(
  parameter int unsigned I_WIDTH   = 8,
  parameter int unsigned F_WIDTH   = 8,
  parameter int unsigned ACC_EXTRA = 4,
  parameter int unsigned N_ACC_MAX = 16,
  parameter int unsigned DEPTH     = 4,
  localparam int unsigned W        = I_WIDTH + F_WIDTH,
  localparam int unsigned ACC_W    = W + ACC_EXTRA,
  localparam int unsigned CNT_W    = $clog2(N_ACC_MAX + 1)
) (
  input  logic                clk_i,
  input  logic                psum_acc_rst_i,
  input  logic signed [W-1:0] in_data_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [CNT_W-1:0]    num_acc_i,
  input  logic                num_acc_ld_i,
  input  logic                relu_en_i,
  input  logic                abort_i,
  output logic [W-1:0]        out_data_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                busy_o,
  output logic                sat_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic signed [ACC_W-1:0] MaxV = {{(ACC_EXTRA + 1){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MinV = {{(ACC_EXTRA + 1){1'b1}}, {(W - 1){1'b0}}};

  typedef enum logic [0:0] {StIdle, StAcc} state_e;

  state_e                   r_state, w_state_d;
  logic signed [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]         r_cnt;
  logic [CNT_W-1:0]         r_num_acc;
  logic                     r_sat;
  logic [W-1:0]             r_mem [DEPTH];
  logic [AW-1:0]            r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]            r_count;

  logic [CNT_W-1:0]         w_eff_num;
  logic                     w_beat, w_last, w_push, w_pop, w_full, w_valid;
  logic signed [ACC_W-1:0]  w_sext, w_sum;
  logic                     w_sat_hi, w_sat_lo;
  logic [W-1:0]             w_res;

  function automatic logic [CNT_W-1:0] clamp_num(input logic [CNT_W-1:0] n);
    if (n == '0) return CNT_W'(1);
    else if (n > CNT_W'(N_ACC_MAX)) return CNT_W'(N_ACC_MAX);
    else return n;
  endfunction

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_valid    = (r_count != '0);
  assign in_ready_o = ~w_full;
  assign w_beat     = in_valid_i & ~w_full & ~abort_i;
  assign w_pop      = w_valid & out_ready_i;

  // A load in the same cycle as the first beat governs that beat.
  assign w_eff_num = (r_state == StIdle && num_acc_ld_i) ? clamp_num(num_acc_i) : r_num_acc;
  assign w_sext    = ACC_W'(in_data_i);
  assign w_sum     = ((r_state == StAcc) ? r_acc : '0) + w_sext;
  assign w_last    = (r_state == StIdle) ? (w_eff_num == CNT_W'(1))
                                         : (r_cnt + CNT_W'(1) == r_num_acc);
  assign w_push    = w_beat & w_last;

  always_comb begin
    w_sat_hi = (w_sum > MaxV);
    w_sat_lo = (w_sum < MinV);
    if (w_sat_hi)      w_res = {1'b0, {(W - 1){1'b1}}};
    else if (w_sat_lo) w_res = {1'b1, {(W - 1){1'b0}}};
    else               w_res = w_sum[W-1:0];
    if (relu_en_i && w_res[W-1]) w_res = '0;
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (psum_acc_rst_i) r_state <= StIdle;
    else                r_state <= w_state_d;
  end

  // FSM next state
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (w_beat && !w_last) w_state_d = StAcc;
      StAcc: begin
        if (abort_i)                  w_state_d = StIdle;
        else if (w_beat && w_last)    w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_o = (r_state == StAcc);
  end

  always_ff @(posedge clk_i) begin
    if (psum_acc_rst_i) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_num_acc <= CNT_W'(1);
      r_sat     <= 1'b0;
    end else begin
      if (r_state == StIdle && num_acc_ld_i) r_num_acc <= clamp_num(num_acc_i);
      if (abort_i) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_beat) begin
        if (w_last) begin
          r_acc <= '0;
          r_cnt <= '0;
          if (w_sat_hi || w_sat_lo) r_sat <= 1'b1;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= w_res;
  end

  always_ff @(posedge clk_i) begin
    if (psum_acc_rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  assign out_valid_o = w_valid;
  assign out_data_o  = w_valid ? r_mem[r_rd_ptr] : '0;
  assign sat_o       = r_sat;

endmodule
